// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_pkg;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_DIGITS_DFLT = 3;
  localparam int BIN_W_DFLT      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one-nibble reverse double-dabble correction (>=8 then -3)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nib_i,
  output logic [BCD_DIGIT_W-1:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - iterative packed-BCD to binary converter; BCD_TO_BIN_ERR_CHECK_EN adds invalid-digit detection
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int BCD_DIGITS = BCD_DIGITS_DFLT,
  parameter int BIN_W      = BIN_W_DFLT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd_in,
  output logic                            busy,
  output logic                            done,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            err
);

  localparam int BCD_W = BCD_DIGIT_W * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic [BCD_W-1:0]   bcd_shift, bcd_adj;
  logic [BIN_W-1:0]   bin_shift;
  logic               last_iter;

  // The shift moves the BCD LSB into the binary MSB; each nibble is then corrected.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .nib_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  logic err_q, err_d;
  logic operand_invalid;

  always_comb begin
    operand_invalid = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) operand_invalid = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bin_out_d = bin_out_q;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
          if (operand_invalid) begin
            state_d   = ST_DONE;
            bin_out_d = '0;
            err_d     = 1'b1;
          end
`endif
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d   = ST_DONE;
          bin_out_d = bin_shift;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
          err_d     = 1'b0;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      bin_out_q <= '0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      bin_out_q <= bin_out_d;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign bin_out = bin_out_q;

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter BCD_DIGITS, default 3: number of packed BCD digits accepted.
REQ-002 Parameter BIN_W, default 10: binary result width; BIN_W >= ceil(log2(10^BCD_DIGITS)).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request conversion of bcd_in; sampled only in IDLE.
REQ-006 bcd_in  input  4*BCD_DIGITS  packed BCD, digit 0 in [3:0], most significant digit in top nibble.
REQ-007 busy  output  1  high whenever FSM is not IDLE.
REQ-008 done  output  1  one-cycle pulse marking bin_out/err valid.
REQ-009 bin_out  output  BIN_W  binary value of last converted operand; held until next accepted start.
REQ-010 err  output  1  invalid-digit flag for last operand; held with bin_out.

Function
REQ-011 Algorithm SHALL be reverse double-dabble: per iteration, shift {bcd_reg, bin_reg} right one bit, then subtract 3 from every bcd_reg nibble >= 8.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; IDLE->SHIFT on start; SHIFT->DONE after BIN_W iterations; DONE->IDLE unconditionally.
REQ-013 On the edge accepting start, bcd_in SHALL be registered, bin_reg cleared, iteration counter cleared.
REQ-014 SHIFT SHALL perform exactly one iteration per cycle, BIN_W cycles total.
REQ-015 done SHALL be high for exactly the one cycle the FSM is in DONE; latency start-edge to done-high = BIN_W+1 cycles (11 at defaults).
REQ-016 bin_out and err SHALL update on the edge entering DONE and remain stable until the edge entering DONE for the next operation.
REQ-017 start while busy SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-018 start high in the DONE cycle SHALL be ignored; start is accepted again from the following IDLE cycle.
REQ-019 bcd_in changes after acceptance SHALL NOT affect the result.
REQ-020 For valid operands, bin_out SHALL equal the decimal value, e.g. 12'h999 -> 10'd999.

Reset
REQ-021 rst SHALL force IDLE with busy=0, done=0, bin_out=0, err=0, and counter and working registers cleared.
REQ-022 rst asserted mid-conversion SHALL abort it with no done pulse; start in the same cycle as rst is ignored.

Configuration
REQ-023 Macro BCD_TO_BIN_ERR_CHECK_EN defined: any bcd_in nibble > 9 at acceptance SHALL skip SHIFT and go IDLE->DONE in one cycle, with err=1 and bin_out=0; done then arrives 2 cycles after start.
REQ-024 Macro undefined: err SHALL be tied to 0, no digit check is performed, all operands take the full BIN_W+1 latency, and bin_out for invalid operands is unspecified.

Structure
REQ-025 Package bcd_pkg SHALL hold the state enum type, the BCD_DIGIT_W=4 constant, and the default BCD_DIGITS and BIN_W constants.
REQ-026 Sub-module bcd_digit_adj SHALL implement one nibble's ">=8 then -3" correction; bcd_to_bin instantiates it BCD_DIGITS times.

Verification
REQ-027 Bench SHALL cover these directed scenarios:
- bcd_in=12'h000, start pulse -> done after 11 cycles, bin_out=0, err=0.
- bcd_in=12'h123, then 12'h255, then 12'h999 -> bin_out=123, 255, 999 respectively, each with 11-cycle latency.
- Operand 12'h037 accepted; new start with 12'h500 at cycle 5 -> ignored; single done with bin_out=37.
- rst high at cycle 4 of a 12'h456 conversion -> no done pulse, all outputs 0; next start with 12'h456 -> bin_out=456.
- With BCD_TO_BIN_ERR_CHECK_EN: bcd_in=12'h1A3 -> done 2 cycles after start, err=1, bin_out=0; following 12'h042 -> err=0, bin_out=42.
- Back-to-back: start held high continuously with 12'h010 -> one conversion every 12 cycles, each bin_out=10.
